// File: rtl/sb_nxm_pkg.sv
// Shared encodings, latched-request record and lane-steering helpers for the sb_nxm system bus.
package sb_nxm_pkg;

  localparam logic [1:0] SB_SIZE_BYTE = 2'b00;
  localparam logic [1:0] SB_SIZE_HALF = 2'b01;
  localparam logic [1:0] SB_SIZE_WORD = 2'b10;

  localparam logic SB_WRITE_ENABLE = 1'b1;
  localparam logic SB_UNSIGNED     = 1'b1;

  typedef enum logic [1:0] {
    SB_ST_IDLE = 2'd0,
    SB_ST_BUSY = 2'd1,
    SB_ST_RESP = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic        we;
    logic        un_sign;
    logic [1:0]  size;
    logic [31:0] wdata;
  } sb_req_t;

  // Illegal size 11 is folded into the alignment error.
  function automatic logic sb_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SB_SIZE_BYTE: bad = 1'b0;
      SB_SIZE_HALF: bad = a[0];
      SB_SIZE_WORD: bad = |a;
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] sb_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SB_SIZE_BYTE: be = 4'b0001 << a;
      SB_SIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SB_SIZE_WORD: be = 4'b1111;
      default:      be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] sb_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      SB_SIZE_BYTE: r = {4{wd[7:0]}};
      SB_SIZE_HALF: r = {2{wd[15:0]}};
      default:      r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sb_extend(input logic [1:0] size, input logic un,
                                            input logic [1:0] a, input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = raw[{a, 3'b000} +: 8];
    h = a[1] ? raw[31:16] : raw[15:0];
    case (size)
      SB_SIZE_BYTE: r = {{24{b[7] & ~un}}, b};
      SB_SIZE_HALF: r = {{16{h[15] & ~un}}, h};
      SB_SIZE_WORD: r = raw;
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_rr_arb.sv
// NM-way round-robin picker: first requester at or after ptr_i, scanning upward with wrap.
module sb_rr_arb #(
  parameter int NM = 2,
  parameter int PW = 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [NM-1:0] gnt_o,
  output logic [PW-1:0] idx_o
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NM; i++) begin
      cand = PW'((int'(ptr_i) + i) % NM);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sb_nxm.sv
// NM-master / NS-slave shared, non-pipelined system bus with round-robin arbitration.
// Define SB_TIMEOUT_EN to abort slave accesses that wait TIMEOUT_CYC cycles without s_ready.
module sb_nxm
  import sb_nxm_pkg::*;
#(
  parameter int NM          = 2,
  parameter int NS          = 2,
  parameter int AW          = 32,
  parameter int SLV_SHIFT   = 28,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     m_req,
  input  logic [NM-1:0]     m_we,
  input  logic [NM-1:0]     m_un_sign,
  input  logic [2*NM-1:0]   m_size,
  input  logic [AW*NM-1:0]  m_addr,
  input  logic [32*NM-1:0]  m_wdata,
  output logic [NM-1:0]     m_gnt,
  output logic [NM-1:0]     m_rvalid,
  output logic [31:0]       m_rdata,
  output logic              m_err,
  output logic [NS-1:0]     s_sel,
  output logic              s_we,
  output logic [3:0]        s_be,
  output logic [AW-1:0]     s_addr,
  output logic [31:0]       s_wdata,
  input  logic [NS-1:0]     s_ready,
  input  logic [32*NS-1:0]  s_rdata
);

  localparam int PW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
  localparam int IW  = AW - SLV_SHIFT;

  sb_state_e      state_q, state_d;
  sb_req_t        req_q, req_d, w_req;
  logic [AW-1:0]  addr_q, addr_d, w_addr;
  logic [IW-1:0]  w_slv;
  logic [PW-1:0]  ptr_q, ptr_d, owner_q, owner_d, win_idx;
  logic [NM-1:0]  win_gnt, gnt_q, gnt_d;
  logic [SIW-1:0] sidx_q, sidx_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d, w_err, acc_act, resp;

`ifdef SB_TIMEOUT_EN
  localparam int TW = 16;
  logic [TW-1:0] cnt_q, cnt_d;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYC);
`endif

  sb_rr_arb #(.NM(NM), .PW(PW)) u_arb (
    .req_i (m_req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign w_addr = m_addr[int'(win_idx)*AW +: AW];
  assign w_req  = '{we:      m_we[win_idx],
                    un_sign: m_un_sign[win_idx],
                    size:    m_size[int'(win_idx)*2 +: 2],
                    wdata:   m_wdata[int'(win_idx)*32 +: 32]};
  assign w_slv  = w_addr[AW-1:SLV_SHIFT];
  // Decode and alignment are judged on the winner's live fields so BUSY knows at entry.
  assign w_err  = (int'(w_slv) >= NS) || sb_misaligned(w_req.size, w_addr[1:0]);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sidx_d  = sidx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt_d   = '0;
`ifdef SB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      SB_ST_IDLE: begin
        if (|m_req) begin
          state_d = SB_ST_BUSY;
          gnt_d   = win_gnt;
          owner_d = win_idx;
          ptr_d   = (int'(win_idx) == NM - 1) ? '0 : win_idx + 1'b1;
          req_d   = w_req;
          addr_d  = w_addr;
          sidx_d  = SIW'(w_slv);
          err_d   = w_err;
          rdata_d = '0;
`ifdef SB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      SB_ST_BUSY: begin
        if (err_q) begin
          state_d = SB_ST_RESP;
        end else if (s_ready[sidx_q]) begin
          state_d = SB_ST_RESP;
          rdata_d = req_q.we ? 32'd0
                  : sb_extend(req_q.size, req_q.un_sign, addr_q[1:0], s_rdata[int'(sidx_q)*32 +: 32]);
`ifdef SB_TIMEOUT_EN
        end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = SB_ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      SB_ST_RESP: state_d = SB_ST_IDLE;
      default:    state_d = SB_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SB_ST_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      sidx_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sidx_q  <= sidx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef SB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign acc_act  = (state_q == SB_ST_BUSY) && !err_q;
  assign resp     = (state_q == SB_ST_RESP);

  assign s_sel    = acc_act ? (NS'(1'b1) << sidx_q) : '0;
  assign s_we     = acc_act && req_q.we;
  assign s_be     = acc_act ? sb_be(req_q.size, addr_q[1:0]) : 4'b0000;
  assign s_addr   = acc_act ? addr_q : '0;
  assign s_wdata  = acc_act ? sb_wdata(req_q.size, req_q.wdata) : 32'd0;

  assign m_gnt    = gnt_q;
  assign m_rvalid = resp ? (NM'(1'b1) << owner_q) : '0;
  assign m_err    = resp && err_q;
  assign m_rdata  = resp ? rdata_q : 32'd0;

endmodule

// File: tb/tb_sb_nxm.sv
// Directed self-checking bench for sb_nxm with two masters and two slaves.
module tb_sb_nxm;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NM-1:0]     m_req = '0, m_we = '0, m_un_sign = '0;
  logic [2*NM-1:0]   m_size = '0;
  logic [AW*NM-1:0]  m_addr = '0;
  logic [32*NM-1:0]  m_wdata = '0;
  logic [NM-1:0]     m_gnt, m_rvalid;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_sel;
  logic              s_we;
  logic [3:0]        s_be;
  logic [AW-1:0]     s_addr;
  logic [31:0]       s_wdata;
  logic [NS-1:0]     s_ready = '0;
  logic [32*NS-1:0]  s_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sb_nxm #(.NM(NM), .NS(NS), .AW(AW), .SLV_SHIFT(28), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_un_sign(m_un_sign), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  task automatic set_master(input int m, input logic we, input logic un, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [1:0] mask;
    mask = 2'(1 << m);
    m_we      = we ? (m_we | mask) : (m_we & ~mask);
    m_un_sign = un ? (m_un_sign | mask) : (m_un_sign & ~mask);
    m_size[2*m +: 2]   = size;
    m_addr[32*m +: 32] = addr;
    m_wdata[32*m +: 32] = wdata;
  endtask

  // One complete transaction from master m; records what the slave side saw.
  task automatic do_access(input int m, input logic we, input logic un, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output logic [1:0] rv,
                           output logic [1:0] sel_seen, output logic [3:0] be_seen,
                           output logic [31:0] wd_seen, output logic we_seen);
    logic [1:0] mask;
    logic done;
    mask = 2'(1 << m);
    rdata = '0; err = 1'b0; rv = '0; sel_seen = '0; be_seen = '0; wd_seen = '0; we_seen = 1'b0;
    done = 1'b0;
    set_master(m, we, un, size, addr, wdata);
    m_req = m_req | mask;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (s_sel != '0) begin
        sel_seen = sel_seen | s_sel; be_seen = s_be; wd_seen = s_wdata; we_seen = s_we;
      end
      if ((m_gnt & mask) != '0) m_req = m_req & ~mask;
      if ((m_rvalid & mask) != '0) begin
        rdata = m_rdata; err = m_err; rv = m_rvalid; done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL access_bound m=%0d addr=%h: got no rvalid in 30 cycles, want rvalid", m, addr);
      m_req = m_req & ~mask;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({m_gnt, m_rvalid, m_rdata, m_err} !== '0) begin
      n_fail++; $display("FAIL reset_master_side: got %h want 0", {m_gnt, m_rvalid, m_rdata, m_err});
    end
    n_tests++;
    if ({s_sel, s_we, s_be, s_addr, s_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_slave_side: got %h want 0", {s_sel, s_we, s_be, s_addr, s_wdata});
    end
    @(negedge clk); @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_latency();
    s_ready = 2'b11;
    s_rdata[31:0] = 32'h8899AABB;
    set_master(0, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0);
    m_req = 2'b01;
    #1;
    n_tests++;
    if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL lat_c0_gnt: got %b want 00", m_gnt); end
    @(negedge clk);
    n_tests++;
    if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL lat_c1_gnt: got %b want 01", m_gnt); end
    n_tests++;
    if (s_sel !== 2'b01) begin n_fail++; $display("FAIL lat_c1_sel: got %b want 01", s_sel); end
    n_tests++;
    if ({s_be, s_addr, s_we} !== {4'b1111, 32'h10, 1'b0}) begin
      n_fail++; $display("FAIL lat_c1_bus: got be=%b addr=%h we=%b want be=1111 addr=10 we=0", s_be, s_addr, s_we);
    end
    n_tests++;
    if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL lat_c1_rvalid: got %b want 00", m_rvalid); end
    m_req = 2'b00;
    @(negedge clk);
    n_tests++;
    if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL lat_c2_rvalid: got %b want 01", m_rvalid); end
    n_tests++;
    if ({m_rdata, m_err} !== {32'h8899AABB, 1'b0}) begin
      n_fail++; $display("FAIL lat_c2_data: got rdata=%h err=%b want 8899aabb err=0", m_rdata, m_err);
    end
    n_tests++;
    if ({m_gnt, s_sel} !== 4'b0000) begin n_fail++; $display("FAIL lat_c2_idle_bus: got gnt=%b sel=%b want 0", m_gnt, s_sel); end
    @(negedge clk);
    n_tests++;
    if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL lat_c3_rvalid_pulse: got %b want 00", m_rvalid); end
  endtask

  task automatic test_read_extend();
    logic [1:0]  t_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        t_un   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_addr [5] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1};
    logic [31:0] t_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234, 32'h00000012};
    logic [31:0] rd, wd; logic er, ws; logic [1:0] rv, sl; logic [3:0] be;
    s_ready = 2'b11;
    s_rdata[31:0] = 32'h80FF1234;
    for (int i = 0; i < 5; i++) begin
      do_access(0, 1'b0, t_un[i], t_size[i], t_addr[i], 32'h0, rd, er, rv, sl, be, wd, ws);
      n_tests++;
      if ({rd, er} !== {t_exp[i], 1'b0}) begin
        n_fail++; $display("FAIL read_ext[%0d]: got rdata=%h err=%b want %h err=0", i, rd, er, t_exp[i]);
      end
    end
  endtask

  task automatic test_write_steer();
    logic [1:0]  t_size [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    logic [31:0] t_addr [4] = '{32'h0000_0002, 32'h0000_0001, 32'h1000_0004, 32'h1000_0003};
    logic [31:0] t_wd   [4] = '{32'h0000_5678, 32'h0000_00A5, 32'hDEADBEEF, 32'h1234_00C3};
    logic [3:0]  t_be   [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    logic [31:0] t_swd  [4] = '{32'h56785678, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hC3C3C3C3};
    logic [1:0]  t_sel  [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic [31:0] rd, wd; logic er, ws; logic [1:0] rv, sl; logic [3:0] be;
    s_ready = 2'b11;
    s_rdata = {32'hCAFEF00D, 32'h80FF1234};
    for (int i = 0; i < 4; i++) begin
      do_access(0, 1'b1, 1'b0, t_size[i], t_addr[i], t_wd[i], rd, er, rv, sl, be, wd, ws);
      n_tests++;
      if ({be, wd, sl, ws} !== {t_be[i], t_swd[i], t_sel[i], 1'b1}) begin
        n_fail++; $display("FAIL write_steer[%0d]: got be=%b wdata=%h sel=%b we=%b want be=%b wdata=%h sel=%b we=1",
                           i, be, wd, sl, ws, t_be[i], t_swd[i], t_sel[i]);
      end
      n_tests++;
      if ({rd, er} !== 33'd0) begin
        n_fail++; $display("FAIL write_resp[%0d]: got rdata=%h err=%b want 0 0", i, rd, er);
      end
    end
  endtask

  task automatic test_ready_select();
    int bad;
    logic done;
    s_rdata = {32'hCAFEF00D, 32'h11111111};
    s_ready = 2'b01;
    set_master(1, 1'b0, 1'b0, 2'b10, 32'h1000_0000, 32'h0);
    m_req = 2'b10;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_gnt != '0) begin m_req = '0; done = 1'b1; end
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL rdysel_gnt: got no gnt want gnt=10"); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_rvalid != '0 || s_sel != 2'b10) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rdysel_wait: got %0d bad cycles want 0", bad); end
    s_ready = 2'b10;
    done = 1'b0;
    for (int c = 0; c < 5 && !done; c++) begin
      @(negedge clk);
      if (m_rvalid != '0) done = 1'b1;
    end
    n_tests++;
    if ({m_rvalid, m_rdata, m_err} !== {2'b10, 32'hCAFEF00D, 1'b0}) begin
      n_fail++; $display("FAIL rdysel_done: got rv=%b rdata=%h err=%b want 10 cafef00d 0", m_rvalid, m_rdata, m_err);
    end
    s_ready = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [1:0]  t_size [6] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] t_addr [6] = '{32'h3000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000,
                                32'h2000_0000, 32'h1FFF_FFFF};
    logic        t_err  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_rd   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFCA};
    logic [1:0]  t_sel  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    logic [31:0] rd, wd; logic er, ws; logic [1:0] rv, sl; logic [3:0] be;
    s_ready = 2'b11;
    s_rdata = {32'hCAFEF00D, 32'h80FF1234};
    for (int i = 0; i < 6; i++) begin
      do_access(1, 1'b0, 1'b0, t_size[i], t_addr[i], 32'h0, rd, er, rv, sl, be, wd, ws);
      n_tests++;
      if ({er, rd, sl, rv} !== {t_err[i], t_rd[i], t_sel[i], 2'b10}) begin
        n_fail++; $display("FAIL error_resp[%0d]: got err=%b rdata=%h sel=%b rv=%b want err=%b rdata=%h sel=%b rv=10",
                           i, er, rd, sl, rv, t_err[i], t_rd[i], t_sel[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g [4];
    logic [1:0] last;
    int ng, nrv, rv0, rv1, own_bad;
    logic [1:0] t_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    s_ready = 2'b11;
    s_rdata = {32'h0000_0002, 32'h0000_0001};
    set_master(0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    set_master(1, 1'b0, 1'b0, 2'b10, 32'h1000_0000, 32'h0);
    m_req = 2'b11;
    ng = 0; nrv = 0; rv0 = 0; rv1 = 0; own_bad = 0; last = '0;
    for (int i = 0; i < 4; i++) g[i] = '0;
    for (int c = 0; c < 60 && nrv < 4; c++) begin
      @(negedge clk);
      if (m_gnt != '0) begin
        if (ng < 4) g[ng] = m_gnt;
        ng++;
        last = m_gnt;
        if (ng == 4) m_req = '0;
      end
      if (m_rvalid != '0) begin
        nrv++;
        if (m_rvalid !== last) own_bad++;
        if (m_rvalid == 2'b01) rv0++; else rv1++;
      end
    end
    m_req = '0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (g[i] !== t_exp[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", i, g[i], t_exp[i]); end
    end
    n_tests++;
    if ({rv0, rv1, own_bad} !== {32'd2, 32'd2, 32'd0}) begin
      n_fail++; $display("FAIL rr_rvalid: got rv0=%0d rv1=%0d misrouted=%0d want 2 2 0", rv0, rv1, own_bad);
    end
    @(negedge clk);
  endtask

`ifdef SB_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd, wd; logic er, ws; logic [1:0] rv, sl; logic [3:0] be;
    s_ready = 2'b00;
    do_access(0, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0, rd, er, rv, sl, be, wd, ws);
    n_tests++;
    if ({er, rd, sl} !== {1'b1, 32'h0, 2'b01}) begin
      n_fail++; $display("FAIL timeout_resp: got err=%b rdata=%h sel=%b want 1 0 01", er, rd, sl);
    end
    s_ready = 2'b11;
    s_rdata[31:0] = 32'h7654_3210;
    do_access(0, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0, rd, er, rv, sl, be, wd, ws);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'h7654_3210}) begin
      n_fail++; $display("FAIL timeout_recover: got err=%b rdata=%h want 0 76543210", er, rd);
    end
  endtask
`endif

  task automatic test_reset_busy();
    logic done;
    int stray;
    s_ready = 2'b00;
    set_master(0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    m_req = 2'b01;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_gnt != '0) done = 1'b1;
    end
    m_req = '0;
    n_tests++;
    if (s_sel !== 2'b01) begin n_fail++; $display("FAIL rstbusy_pre_sel: got %b want 01", s_sel); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({m_gnt, m_rvalid, m_rdata, m_err, s_sel, s_we, s_be, s_addr, s_wdata} !== '0) begin
      n_fail++; $display("FAIL rstbusy_outputs: got gnt=%b rv=%b sel=%b be=%b addr=%h want all 0",
                         m_gnt, m_rvalid, s_sel, s_be, s_addr);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m_rvalid != '0) stray++;
    end
    n_tests++;
    if (stray != 0) begin n_fail++; $display("FAIL rstbusy_no_rvalid: got %0d pulses want 0", stray); end
    s_ready = 2'b11;
    s_rdata = {32'h0A0B0C0D, 32'h01020304};
    set_master(1, 1'b0, 1'b0, 2'b10, 32'h1000_0000, 32'h0);
    m_req = 2'b11;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_gnt != '0) done = 1'b1;
    end
    n_tests++;
    if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rstbusy_ptr_restart: got gnt=%b want 01", m_gnt); end
    m_req = '0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_rvalid != '0) done = 1'b1;
    end
    n_tests++;
    if ({m_rvalid, m_rdata, m_err} !== {2'b01, 32'h01020304, 1'b0}) begin
      n_fail++; $display("FAIL rstbusy_fresh: got rv=%b rdata=%h err=%b want 01 01020304 0", m_rvalid, m_rdata, m_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_read_extend();
    test_write_steer();
    test_ready_select();
    test_errors();
    test_round_robin();
`ifdef SB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_nxm.md
Name: sb_nxm

Overview:
- Parametrised successor to the two-master, one-slave system bus.
- Connects NM masters (core LSU, DMA, debug) to NS address-decoded slaves (dmem, peripherals) over one shared, non-pipelined path.
- Round-robin arbitration, a request/grant/response handshake, byte-lane steering, read sign/zero extension, and error responses for unmapped or misaligned accesses.
- Sits between CoNM master ports and the dmem/peripheral slaves in the SoC top.

Parameters:
- NM, 2: number of masters (1..8).
- NS, 2: number of slaves (1..8).
- AW, 32: address width.
- SLV_SHIFT, 28: slave index is addr[AW-1:SLV_SHIFT]; index >= NS is unmapped.
- TIMEOUT_CYC, 255: slave-wait limit in cycles (only with the optional feature).
- Data width is fixed at 32.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- m_req  in  NM  per-master request; held high until m_gnt.
- m_we  in  NM  1 = write, 0 = read.
- m_un_sign  in  NM  1 = zero-extend read data, 0 = sign-extend.
- m_size  in  2*NM  00 byte, 01 half, 10 word; 11 is illegal and gives an error.
- m_addr  in  AW*NM  byte address.
- m_wdata  in  32*NM  write data, right-aligned.
- m_gnt  out  NM  one-cycle pulse; request accepted and fields latched.
- m_rvalid  out  NM  one-cycle pulse to the owning master; access complete.
- m_rdata  out  32  extended read data; valid with m_rvalid; 0 for writes and errors.
- m_err  out  1  qualifies m_rvalid; 1 = decode, alignment or timeout error.
- s_sel  out  NS  one-hot slave select.
- s_we  out  1  write strobe.
- s_be  out  4  byte enables.
- s_addr  out  AW  latched address.
- s_wdata  out  32  lane-replicated write data.
- s_ready  in  NS  slave completes the access this cycle.
- s_rdata  in  32*NS  raw slave read word.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, RR pointer 0, latched fields 0.
- Reset during any state aborts the access; no m_rvalid is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any m_req is high, pick the winner: first requester at or after the RR pointer, scanning upward with wrap.
  - Latch the winner's we, un_sign, size, addr and wdata.
  - Pulse m_gnt[winner] (registered, so it appears the cycle after req is seen) and go to BUSY.
  - RR pointer becomes winner+1 (mod NM).
- Entry check into BUSY. Error if any of:
  - slave index >= NS;
  - size 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0.
  - On error: s_sel stays 0, next state is RESP with err = 1, no slave access.
- BUSY (legal access):
  - s_sel[idx] = 1; s_we, s_be, s_addr, s_wdata are driven from the latched fields.
  - When s_ready[idx] is high, capture s_rdata[idx] and go to RESP.
  - s_ready from non-selected slaves is ignored.
- RESP:
  - m_rvalid[owner] = 1 for exactly one cycle; m_err and m_rdata are valid.
  - Return to IDLE, and arbitration for the next access starts in that IDLE cycle.
- Minimum latency: req seen at cycle 0, gnt at cycle 1, slave select at cycle 1, ready at cycle 1, rvalid at cycle 2.
- s_be:
  - byte: 1 << addr[1:0];
  - half: 0011 if addr[1] = 0, else 1100;
  - word: 1111.
- s_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Read extension: select the lane by addr[1:0], then extend to 32 bits using un_sign.
- A master whose req is high but which is not granted keeps waiting. It is served within NM accesses (starvation-free).
- A new request from the current owner during BUSY/RESP is not accepted until IDLE.

Optional Feature:
- SB_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC without s_ready, s_sel drops and the FSM goes to RESP with m_err = 1 and m_rdata = 0.
  - A s_ready arriving in the same cycle as expiry wins: normal completion.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Add to defines.v (shared):
  - SB_SIZE_BYTE/HALF/WORD codes.
  - SB_ST_IDLE/BUSY/RESP state encodings.
  - Existing UNSIGNED / WRITE_ENABLE style constants.
- One sub-module, sb_rr_arb:
  - Parametrised NM-way round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and encoded index.
- Lane steering and extension stay inline.

Test Plan:
- Single master reads word at 0x0000_0010 from slave 0 returning 0x8899AABB, ready immediate -> gnt at cycle 1, rvalid at cycle 2, m_rdata = 0x8899AABB, m_err = 0.
- Byte read at 0x...03, s_rdata 0x80FF1234: signed -> 0xFFFFFF80; unsigned -> 0x00000080. Half write of 0x5678 at 0x...02 -> s_be = 1100, s_wdata = 0x56785678.
- Masters 0 and 1 request continuously for 4 accesses -> grants in order 0, 1, 0, 1; each master gets exactly one rvalid per gnt.
- Address 0x3000_0000 with NS = 2 -> s_sel never asserts; rvalid with m_err = 1, m_rdata = 0. Word at 0x...02 -> same error response.
- SB_TIMEOUT_EN with TIMEOUT_CYC = 4 and slave never ready -> m_err = 1 after the timeout; next request is serviced normally.
- rst driven low while in BUSY -> all outputs 0 immediately; after release, a fresh request completes with the RR pointer restarting at master 0.
